tpiu_frame_assembler: RTL and testbench
=======================================

TPIU_FRAME_ASSEMBLER -- requirements
Module: tpiu_frame_assembler

Interface
REQ-001 Parameter SYNC_TO_LOG2, default 16, sets the sync-loss timeout: 2^SYNC_TO_LOG2 accepted words without a full sync.
REQ-002 clk  input  1  system clock; all logic is on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 WordIn  input  16  next TPIU halfword from the pin sampler, little-endian.
REQ-005 WordValid  input  1  WordIn is valid this cycle; single-cycle qualifier with no backpressure.
REQ-006 FrameOut  output  128  last completed frame, registered.
REQ-007 FrAvail  output  1  toggles once per completed frame; the consumer edge-detects it through its 3-flop synchroniser.
REQ-008 Synced  output  1  frame alignment established.
REQ-009 FramesOut  output  32  count of completed frames.
REQ-010 PartialFrames  output  32  count of partial frames discarded by a resync.

Function
REQ-011 A halfword is accepted only in cycles where WordValid=1; all state is held otherwise.
REQ-012 Every accepted word shifts into a 64-bit history register, newest word in bits [15:0].
REQ-013 Full sync is detected when the history, after shifting, equals 64'hFFFF_FFFF_FFFF_7FFF (oldest word in the MSBs).
REQ-014 On full-sync detection:
- Synced<=1.
- Word index WIdx<=0.
- Timeout counter<=0.
- The detected sync word is not stored.
REQ-015 On full-sync detection with Synced=1 and WIdx!=3, PartialFrames increments; WIdx==3 is the aligned case (three FFFF words already counted) and does not increment.
REQ-016 While Synced=0, accepted words are not assembled and FrAvail does not toggle.
REQ-017 While Synced=1, WIdx=0 and WordIn=16'h7FFF (halfword sync/idle), the word is discarded: WIdx is unchanged and the timeout counter still advances.
REQ-018 Otherwise, while Synced=1, the word is written to assembly register bits [16*WIdx+15:16*WIdx], and WIdx increments modulo 8 (3-bit wrap).
REQ-019 On acceptance with WIdx=7, on the same clock edge:
- FrameOut<= completed frame (including this word).
- FrAvail<=~FrAvail.
- FramesOut increments.
REQ-020 Latency: FrameOut and FrAvail change on the edge that accepts the 8th word; the consumer sees them one edge later.
REQ-021 FrameOut is held constant between toggles, a minimum of 8 WordValid cycles.
REQ-022 The timeout counter is SYNC_TO_LOG2 bits wide and increments on every accepted word while Synced=1.
REQ-023 When the timeout counter wraps to 0 without a full sync, Synced<=0 and WIdx<=0; the partial frame is discarded without counting.
REQ-024 Full-sync detection takes priority over timeout, halfsync discard and frame completion in the same cycle.
REQ-025 FramesOut and PartialFrames wrap modulo 2^32.
REQ-026 The history register updates regardless of Synced.

Reset
REQ-027 While rst=1, all of the following are 0:
- FrameOut, FrAvail, Synced, FramesOut, PartialFrames.
- History register, assembly register, WIdx, timeout counter.
REQ-028 Reset asserted mid-frame discards the partial frame without counting; after release, Synced=0 until a new full sync.
REQ-029 No output glitches on reset release; the first accepted word after release is processed normally.

Verification
REQ-030 Unsynced: stream 0x0000..0x0020 -> Synced=0, FrAvail constant 0, FramesOut=0.
REQ-031 Aligned frame: FFFF,FFFF,FFFF,7FFF then 0x0001..0x0008 ->
- Synced=1 after the 4th word.
- FrAvail 0->1 on the 12th accepted word.
- FrameOut=128'h0008_0007_0006_0005_0004_0003_0002_0001, FramesOut=1.
REQ-032 Halfsync filler:
- Synced, then 7FFF,7FFF,0x1111, then 7 more words -> 7FFF words discarded; one frame with bits[15:0]=16'h1111.
- A 7FFF at WIdx=3 is stored as data.
REQ-033 Mid-frame resync: synced, 5 data words, then FFFF,FFFF,FFFF,7FFF ->
- At detection WIdx=0 (3 data + 5 prior), PartialFrames=1, FrAvail unchanged.
- The next 8 words form a frame.
REQ-034 Timeout, SYNC_TO_LOG2=4: sync, then 16 accepted non-sync words ->
- Synced drops on the 16th word.
- Exactly 2 frames emitted, FramesOut=2.
REQ-035 Gapped input and reset: WordValid toggled 1/0 with random gaps gives results identical to REQ-031; rst pulsed after word 5 of a frame leaves all outputs 0 and Synced=0 until a new sync.

Source files
------------

// File: rtl/tpiu_frame_assembler_if.sv
// TPIU frame assembler bus: halfword input from the pin sampler and the
// assembled-frame outputs toward the trace consumer.
interface tpiu_frame_assembler_if;
    logic [15:0]  WordIn;
    logic         WordValid;
    logic [127:0] FrameOut;
    logic         FrAvail;
    logic         Synced;
    logic [31:0]  FramesOut;
    logic [31:0]  PartialFrames;

    // Sampler / test side: drives halfwords, observes frames.
    modport master (
        output WordIn,
        output WordValid,
        input  FrameOut,
        input  FrAvail,
        input  Synced,
        input  FramesOut,
        input  PartialFrames
    );

    // Assembler side.
    modport slave (
        input  WordIn,
        input  WordValid,
        output FrameOut,
        output FrAvail,
        output Synced,
        output FramesOut,
        output PartialFrames
    );
endinterface

// File: rtl/tpiu_frame_assembler.sv
// TPIU frame assembler: finds full-sync alignment in the halfword stream,
// drops halfword-sync fillers at frame start, and packs eight halfwords into
// a 128-bit frame. FrAvail toggles per frame for a CDC edge-detect consumer.
module tpiu_frame_assembler #(
    parameter int unsigned SYNC_TO_LOG2 = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    tpiu_frame_assembler_if.slave  bus
);

    localparam logic [63:0]             FullSync = 64'hFFFF_FFFF_FFFF_7FFF;
    localparam logic [15:0]             HalfSync = 16'h7FFF;
    localparam logic [SYNC_TO_LOG2-1:0] TmoOne   = {{(SYNC_TO_LOG2-1){1'b0}}, 1'b1};

    logic [63:0]             hist_q, hist_d;
    logic [127:0]            asm_q, asm_d;
    logic [2:0]              widx_q, widx_d;
    logic [SYNC_TO_LOG2-1:0] tmo_q, tmo_d;
    logic                    synced_q, synced_d;
    logic [127:0]            frame_q, frame_d;
    logic                    fr_avail_q, fr_avail_d;
    logic [31:0]             frames_q, frames_d;
    logic [31:0]             partial_q, partial_d;

    // Next-state: sync search, filler drop, frame packing and sync-loss timeout.
    always_comb begin
        hist_d     = hist_q;
        asm_d      = asm_q;
        widx_d     = widx_q;
        tmo_d      = tmo_q;
        synced_d   = synced_q;
        frame_d    = frame_q;
        fr_avail_d = fr_avail_q;
        frames_d   = frames_q;
        partial_d  = partial_q;

        if (bus.WordValid) begin
            hist_d = {hist_q[47:0], bus.WordIn};
            if (hist_d == FullSync) begin
                // Realign; WIdx==3 means the three FFFF words filled slots 0..2
                // of an otherwise aligned stream, so nothing real was lost.
                synced_d = 1'b1;
                widx_d   = 3'd0;
                tmo_d    = '0;
                if (synced_q && (widx_q != 3'd3)) begin
                    partial_d = partial_q + 32'd1;
                end
            end else if (synced_q) begin
                tmo_d = tmo_q + TmoOne;
                if (!((widx_q == 3'd0) && (bus.WordIn == HalfSync))) begin
                    asm_d[16*widx_q +: 16] = bus.WordIn;
                    widx_d = widx_q + 3'd1;
                    if (widx_q == 3'd7) begin
                        frame_d    = asm_d;
                        fr_avail_d = ~fr_avail_q;
                        frames_d   = frames_q + 32'd1;
                    end
                end
                // Timeout still lets the completing word emit its frame.
                if (tmo_d == '0) begin
                    synced_d = 1'b0;
                    widx_d   = 3'd0;
                end
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q     <= '0;
            asm_q      <= '0;
            widx_q     <= '0;
            tmo_q      <= '0;
            synced_q   <= 1'b0;
            frame_q    <= '0;
            fr_avail_q <= 1'b0;
            frames_q   <= '0;
            partial_q  <= '0;
        end else begin
            hist_q     <= hist_d;
            asm_q      <= asm_d;
            widx_q     <= widx_d;
            tmo_q      <= tmo_d;
            synced_q   <= synced_d;
            frame_q    <= frame_d;
            fr_avail_q <= fr_avail_d;
            frames_q   <= frames_d;
            partial_q  <= partial_d;
        end
    end

    assign bus.FrameOut      = frame_q;
    assign bus.FrAvail       = fr_avail_q;
    assign bus.Synced        = synced_q;
    assign bus.FramesOut     = frames_q;
    assign bus.PartialFrames = partial_q;

endmodule

// File: tb/tb_tpiu_frame_assembler.sv
// Directed bench for tpiu_frame_assembler: default instance plus a short
// timeout instance (SYNC_TO_LOG2=4) fed the same stimulus.
module tb_tpiu_frame_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] word_in = '0;
    logic        word_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    tpiu_frame_assembler_if bus ();
    tpiu_frame_assembler_if bus_to ();

    assign bus.WordIn       = word_in;
    assign bus.WordValid    = word_valid;
    assign bus_to.WordIn    = word_in;
    assign bus_to.WordValid = word_valid;

    tpiu_frame_assembler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    tpiu_frame_assembler #(
        .SYNC_TO_LOG2 (4)
    ) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bus_to.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic push(input logic [15:0] w);
        word_in    = w;
        word_valid = 1'b1;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        word_in    = 16'hDEAD;
    endtask

    task automatic gpush(input logic [15:0] w);
        int n;
        push(w);
        n = $urandom_range(0, 3);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_sync();
        push(16'hFFFF);
        push(16'hFFFF);
        push(16'hFFFF);
        push(16'h7FFF);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_frame", bus.FrameOut, '0);
        chk("rst_fravail", {127'd0, bus.FrAvail}, 128'd0);
        chk("rst_synced", {127'd0, bus.Synced}, 128'd0);
        chk("rst_frames", {96'd0, bus.FramesOut}, 128'd0);
        chk("rst_partial", {96'd0, bus.PartialFrames}, 128'd0);
        rst = 1'b0;

        // Unsynced stream
        for (int i = 0; i <= 32; i++) push(16'(i));
        chk("unsync_synced", {127'd0, bus.Synced}, 128'd0);
        chk("unsync_fravail", {127'd0, bus.FrAvail}, 128'd0);
        chk("unsync_frames", {96'd0, bus.FramesOut}, 128'd0);

        // Aligned frame
        push(16'hFFFF);
        push(16'hFFFF);
        push(16'hFFFF);
        chk("al_presync", {127'd0, bus.Synced}, 128'd0);
        push(16'h7FFF);
        chk("al_synced", {127'd0, bus.Synced}, 128'd1);
        for (int i = 1; i <= 7; i++) push(16'(i));
        chk("al_fravail_11", {127'd0, bus.FrAvail}, 128'd0);
        push(16'h0008);
        chk("al_fravail_12", {127'd0, bus.FrAvail}, 128'd1);
        chk("al_frame", bus.FrameOut, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("al_frames", {96'd0, bus.FramesOut}, 128'd1);
        chk("al_partial", {96'd0, bus.PartialFrames}, 128'd0);

        // Halfsync filler; 7FFF at slot 3 is data
        push(16'h7FFF);
        push(16'h7FFF);
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h7FFF);
        push(16'h5555);
        push(16'h6666);
        push(16'h7777);
        chk("hs_pending", {96'd0, bus.FramesOut}, 128'd1);
        push(16'h8888);
        chk("hs_frame", bus.FrameOut, 128'h8888_7777_6666_5555_7FFF_3333_2222_1111);
        chk("hs_fravail", {127'd0, bus.FrAvail}, 128'd0);
        chk("hs_frames", {96'd0, bus.FramesOut}, 128'd2);

        // Mid-frame resync: third FFFF completes a frame, 7FFF then realigns
        for (int i = 1; i <= 5; i++) push(16'hA000 + 16'(i));
        push(16'hFFFF);
        push(16'hFFFF);
        push(16'hFFFF);
        chk("rs_frame_ffff", bus.FrameOut, 128'hFFFF_FFFF_FFFF_A005_A004_A003_A002_A001);
        chk("rs_fravail_pre", {127'd0, bus.FrAvail}, 128'd1);
        push(16'h7FFF);
        chk("rs_partial", {96'd0, bus.PartialFrames}, 128'd1);
        chk("rs_fravail_det", {127'd0, bus.FrAvail}, 128'd1);
        chk("rs_frames_det", {96'd0, bus.FramesOut}, 128'd3);
        for (int i = 1; i <= 8; i++) push(16'hB000 + 16'(i));
        chk("rs_frame_next", bus.FrameOut, 128'hB008_B007_B006_B005_B004_B003_B002_B001);
        chk("rs_frames", {96'd0, bus.FramesOut}, 128'd4);
        chk("rs_fravail", {127'd0, bus.FrAvail}, 128'd0);

        // Gapped input reproduces the aligned-frame result
        rst_pulse();
        gpush(16'hFFFF);
        gpush(16'hFFFF);
        gpush(16'hFFFF);
        gpush(16'h7FFF);
        for (int i = 1; i <= 8; i++) gpush(16'(i));
        chk("gap_frame", bus.FrameOut, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("gap_frames", {96'd0, bus.FramesOut}, 128'd1);
        chk("gap_fravail", {127'd0, bus.FrAvail}, 128'd1);
        chk("gap_synced", {127'd0, bus.Synced}, 128'd1);
        chk("gap_partial", {96'd0, bus.PartialFrames}, 128'd0);

        // Aligned resync (WIdx==3) is not partial; then reset after word 5
        push_sync();
        chk("al3_partial", {96'd0, bus.PartialFrames}, 128'd0);
        for (int i = 1; i <= 5; i++) push(16'(i));
        rst = 1'b1;
        #2;
        chk("mr_frame", bus.FrameOut, '0);
        chk("mr_fravail", {127'd0, bus.FrAvail}, 128'd0);
        chk("mr_synced", {127'd0, bus.Synced}, 128'd0);
        chk("mr_frames", {96'd0, bus.FramesOut}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 6; i <= 11; i++) push(16'(i));
        chk("mr_still_unsync", {127'd0, bus.Synced}, 128'd0);
        chk("mr_no_frames", {96'd0, bus.FramesOut}, 128'd0);
        push_sync();
        chk("mr_resynced", {127'd0, bus.Synced}, 128'd1);
        chk("mr_partial", {96'd0, bus.PartialFrames}, 128'd0);
        for (int i = 1; i <= 8; i++) push(16'hD000 + 16'(i));
        chk("mr_frame_new", bus.FrameOut, 128'hD008_D007_D006_D005_D004_D003_D002_D001);
        chk("mr_frames_new", {96'd0, bus.FramesOut}, 128'd1);

        // Timeout on the SYNC_TO_LOG2=4 instance
        rst_pulse();
        push_sync();
        chk("to_synced", {127'd0, bus_to.Synced}, 128'd1);
        for (int i = 1; i <= 15; i++) push(16'hC000 + 16'(i));
        chk("to_synced_15", {127'd0, bus_to.Synced}, 128'd1);
        chk("to_frames_15", {96'd0, bus_to.FramesOut}, 128'd1);
        push(16'hC010);
        chk("to_dropped", {127'd0, bus_to.Synced}, 128'd0);
        chk("to_frames_16", {96'd0, bus_to.FramesOut}, 128'd2);
        chk("to_frame", bus_to.FrameOut, 128'hC010_C00F_C00E_C00D_C00C_C00B_C00A_C009);
        chk("to_def_synced", {127'd0, bus.Synced}, 128'd1);
        for (int i = 1; i <= 8; i++) push(16'hE000 + 16'(i));
        chk("to_frames_after", {96'd0, bus_to.FramesOut}, 128'd2);
        chk("to_fravail_after", {127'd0, bus_to.FrAvail}, 128'd0);
        chk("to_partial", {96'd0, bus_to.PartialFrames}, 128'd0);
        chk("to_def_frames", {96'd0, bus.FramesOut}, 128'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
